multi_channel_tester: RTL and testbench



---
 rtl/multi_channel_tester.sv | 108 ++++++++++
 tb/tb_multi_channel_tester.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_tester.sv
// multi_channel_tester: per-channel pattern generator (tx) and lock/error checker (rx); user_clk/peripheral_reset, shared enable/mode/err_clear, per-channel channel_up, tx_t*, rx_t*, error_counter, locked
module multi_channel_tester #(
  parameter int NUM_CH = 1,
  parameter int DATA_W = 32,
  parameter int ERR_CNT_W = 4,
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 8
) (
  input  logic                        user_clk,
  input  logic                        peripheral_reset,
  input  logic                        enable,
  input  logic [1:0]                  mode,
  input  logic                        err_clear,
  input  logic [NUM_CH-1:0]           channel_up,
  output logic [NUM_CH*DATA_W-1:0]    tx_tdata,
  output logic [NUM_CH-1:0]           tx_tvalid,
  input  logic [NUM_CH-1:0]           tx_tready,
  input  logic [NUM_CH*DATA_W-1:0]    rx_tdata,
  input  logic [NUM_CH-1:0]           rx_tvalid,
  output logic [NUM_CH*ERR_CNT_W-1:0] error_counter,
  output logic [NUM_CH-1:0]           locked
);
  localparam int CW = $clog2((LOCK_CNT > LOSS_CNT ? LOCK_CNT : LOSS_CNT) + 1);
  typedef enum logic [1:0] {IDLE, SEEK, LOCKING, LOCKED} st_t;
  function automatic logic [DATA_W-1:0] prbs_word(input logic [14:0] s0, input logic p15);
    logic [14:0] s;
    logic b;
    logic [DATA_W-1:0] w;
    s = s0;
    w = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      b = p15 ? s[14] ^ s[13] : s[6] ^ s[5];
      s = {s[13:0], b};
      w[i] = b;
    end
    return w;
  endfunction
  function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] w, input logic [1:0] m);
    return m == 2'd1 ? prbs_word(w[14:0], 1'b0) : m == 2'd2 ? prbs_word(w[14:0], 1'b1) : w + DATA_W'(1);
  endfunction
  function automatic logic [DATA_W-1:0] seed_word(input logic [1:0] m);
    return (m == 2'd1 || m == 2'd2) ? next_word('1, m) : '0;
  endfunction
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] txw, rxw, exp;
    logic [1:0] tm, cm;
    logic tv, act, beat, miss;
    st_t st;
    logic [CW-1:0] cnt;
    logic [ERR_CNT_W-1:0] err;
    assign act = enable & channel_up[c];
    assign rxw = rx_tdata[c*DATA_W +: DATA_W];
    assign beat = rx_tvalid[c];
    assign miss = rxw != exp;
    assign tx_tdata[c*DATA_W +: DATA_W] = txw;
    assign tx_tvalid[c] = tv;
    assign error_counter[c*ERR_CNT_W +: ERR_CNT_W] = err;
    assign locked[c] = st == LOCKED;
    always_ff @(posedge user_clk or posedge peripheral_reset) begin
      if (peripheral_reset) begin
        tv <= 1'b0;
        txw <= '0;
        tm <= '0;
      end else if (!channel_up[c]) begin
        tv <= 1'b0;
      end else if (tv) begin
        if (tx_tready[c]) begin
          tv <= enable;
          txw <= next_word(txw, tm);
        end
      end else if (enable) begin
        tv <= 1'b1;
        tm <= mode;
        txw <= seed_word(mode);
      end
    end
    always_ff @(posedge user_clk or posedge peripheral_reset) begin
      if (peripheral_reset) begin
        st <= IDLE;
        cm <= '0;
        exp <= '0;
        cnt <= '0;
        err <= '0;
      end else begin
        if (err_clear) err <= '0;
        else if (act && st == LOCKED && beat && miss && err != '1) err <= err + ERR_CNT_W'(1);
        if (!act) begin
          st <= IDLE;
        end else if (st == IDLE) begin
          st <= SEEK;
          cm <= mode;
        end else if (beat) begin
          exp <= next_word(st == SEEK ? rxw : exp, cm);
          if (st == SEEK) begin
            st <= LOCKING;
            cnt <= '0;
          end else if (st == LOCKING) begin
            st <= miss ? SEEK : cnt == CW'(LOCK_CNT - 1) ? LOCKED : LOCKING;
            cnt <= (miss || cnt == CW'(LOCK_CNT - 1)) ? '0 : cnt + CW'(1);
          end else begin
            st <= (miss && cnt == CW'(LOSS_CNT - 1)) ? SEEK : LOCKED;
            cnt <= (miss && cnt != CW'(LOSS_CNT - 1)) ? cnt + CW'(1) : '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_channel_tester.sv
// tb_multi_channel_tester: randomized loopback bench against a behavioural pattern/lock model
`timescale 1ns/1ps
module tb_multi_channel_tester;
  localparam int NC = 2, DW = 32, EW = 4, LOCK_N = 16, LOSS_N = 8;
  localparam int P_IDLE = 0, P_SEEK = 1, P_LOCKING = 2, P_LOCKED = 3;
  logic clk = 0, rst = 1, en = 0, ec = 0;
  logic [1:0] mode = 0, up = 0, rdy = 0;
  logic [NC*DW-1:0] flip = '0;
  logic [NC*DW-1:0] txd, rxd;
  logic [NC-1:0] txv, rxv, lk;
  logic [NC*EW-1:0] errc;
  int tests = 0, fails = 0, beats0 = 0;
  bit chk_on = 0;
  logic [31:0] m_tx[NC], m_exp[NC];
  bit m_txv[NC];
  int m_txmode[NC], m_cmode[NC], ph[NC], run[NC], m_err[NC];
  assign rxd = txd ^ flip;
  assign rxv = txv & rdy;
  multi_channel_tester #(.NUM_CH(NC), .DATA_W(DW), .ERR_CNT_W(EW), .LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N)) dut (
    .user_clk(clk), .peripheral_reset(rst), .enable(en), .mode(mode), .err_clear(ec),
    .channel_up(up), .tx_tdata(txd), .tx_tvalid(txv), .tx_tready(rdy),
    .rx_tdata(rxd), .rx_tvalid(rxv), .error_counter(errc), .locked(lk));
  initial forever #2.5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  function automatic logic [31:0] pat_next(input logic [31:0] w, input int m);
    logic [31:0] r;
    int n, s, b;
    r = '0;
    if (m == 1 || m == 2) begin
      n = m == 1 ? 7 : 15;
      s = int'({17'b0, w[14:0]}) & ((1 << n) - 1);
      for (int i = 0; i < 32; i++) begin
        b = ((s >> (n - 1)) ^ (s >> (n - 2))) & 1;
        s = ((s << 1) | b) & ((1 << n) - 1);
        r = {r[30:0], b[0]};
      end
    end else r = w + 32'd1;
    return r;
  endfunction
  function automatic logic [31:0] pat_seed(input int m);
    return (m == 1 || m == 2) ? pat_next('1, m) : 32'd0;
  endfunction
  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_tx[c] = 0; m_exp[c] = 0; m_txv[c] = 0; m_txmode[c] = 0;
      m_cmode[c] = 0; ph[c] = P_IDLE; run[c] = 0; m_err[c] = 0;
    end
  endfunction
  function automatic void model_update();
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NC; c++) begin
      bit b, ok;
      logic [31:0] rw;
      b = m_txv[c] && rdy[c];
      rw = m_tx[c] ^ flip[c*DW +: DW];
      if (!(en && up[c])) ph[c] = P_IDLE;
      else if (ph[c] == P_IDLE) begin
        ph[c] = P_SEEK;
        m_cmode[c] = int'(mode);
      end else if (b) begin
        if (ph[c] == P_SEEK) begin
          m_exp[c] = pat_next(rw, m_cmode[c]);
          run[c] = 0;
          ph[c] = P_LOCKING;
        end else begin
          ok = rw == m_exp[c];
          m_exp[c] = pat_next(m_exp[c], m_cmode[c]);
          if (ph[c] == P_LOCKING) begin
            if (ok) begin
              run[c]++;
              if (run[c] == LOCK_N) begin ph[c] = P_LOCKED; run[c] = 0; end
            end else begin ph[c] = P_SEEK; run[c] = 0; end
          end else if (ok) run[c] = 0;
          else begin
            run[c]++;
            if (m_err[c] < (1 << EW) - 1) m_err[c]++;
            if (run[c] == LOSS_N) begin ph[c] = P_SEEK; run[c] = 0; end
          end
        end
      end
      if (ec) m_err[c] = 0;
      if (!up[c]) m_txv[c] = 0;
      else if (m_txv[c]) begin
        if (b) begin
          m_tx[c] = pat_next(m_tx[c], m_txmode[c]);
          m_txv[c] = en;
        end
      end else if (en) begin
        m_txv[c] = 1;
        m_txmode[c] = int'(mode);
        m_tx[c] = pat_seed(int'(mode));
      end
      if (c == 0 && b) beats0++;
    end
  endfunction
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask
  always @(negedge clk) if (chk_on) for (int c = 0; c < NC; c++) begin
    check($sformatf("tx_tvalid[%0d]", c), txv[c], m_txv[c]);
    if (m_txv[c]) check($sformatf("tx_tdata[%0d]", c), txd[c*DW +: DW], m_tx[c]);
    check($sformatf("locked[%0d]", c), lk[c], ph[c] == P_LOCKED);
    check($sformatf("error_counter[%0d]", c), errc[c*EW +: EW], m_err[c]);
  end
  initial begin
    int cyc;
    model_reset();
    chk_on = 1;
    check("pin_prbs7_seed", pat_seed(1), 32'h020C28F2);
    check("pin_cnt_seed", pat_seed(0), 0);
    check("pin_cnt_next", pat_next(32'hFFFFFFFF, 3), 0);
    repeat (200) step();
    rst = 0;
    mode = 0; en = 1; up = 2'b11; rdy = 2'b11; beats0 = 0; cyc = 0;
    while (lk !== 2'b11 && cyc < 100) begin step(); cyc++; end
    check("lock_beats", beats0, 17);
    repeat (10000) step();
    check("clean_errors", errc, 0);
    flip[DW+3] = 1; step(); flip = '0; step();
    check("ch1_single_err", errc, 8'h10);
    check("ch1_still_locked", lk, 2'b11);
    repeat (20) begin flip[5] = 1; step(); flip = '0; repeat (3) step(); end
    check("ch0_saturate", errc, 8'h1F);
    check("isolated_locked", lk, 2'b11);
    ec = 1; flip[0] = 1; step(); ec = 0; flip = '0;
    check("clear_priority", errc, 0);
    repeat (3) step();
    flip[9] = 1; repeat (8) step(); flip = '0;
    check("loss_unlock", lk, 2'b10);
    check("loss_errs", errc, 8'h08);
    repeat (16) step();
    check("relock_16", lk, 2'b10);
    step();
    check("relock_17", lk, 2'b11);
    rdy = 0; en = 0; step();
    check("hold_pending", txv, 2'b11);
    rdy = 2'b11; step();
    check("drop_after_beat", txv, 2'b00);
    for (int m = 1; m <= 2; m++) begin
      ec = 1; step(); ec = 0;
      mode = 2'(m); en = 1; rdy = 2'b11; step();
      if (m == 1) check("prbs7_first_word", txd[31:0], 32'h020C28F2);
      repeat (3000) begin
        rdy = 2'($urandom);
        if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
        step();
      end
      rdy = 2'b11; repeat (20) step();
      check($sformatf("prbs%0d_errors", m), errc, 0);
      check($sformatf("prbs%0d_locked", m), lk, 2'b11);
      if (m == 1) begin en = 0; repeat (3) step(); end
    end
    up = 2'b01; step();
    check("up_drop_txv", txv[1], 0);
    check("up_drop_lock", lk[1], 0);
    check("up_drop_ch0", lk[0], 1);
    repeat (4000) begin
      rdy = 2'($urandom);
      flip = '0;
      if ($urandom_range(0, 15) == 0) flip[$urandom_range(0, NC*DW-1)] = 1;
      if ($urandom_range(0, 199) == 0) up = 2'($urandom);
      if ($urandom_range(0, 99) == 0) up = 2'b11;
      if ($urandom_range(0, 149) == 0) en = ~en;
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom);
      ec = $urandom_range(0, 299) == 0;
      step();
    end
    flip = '0; ec = 0; en = 1; up = 2'b11; rdy = 2'b11;
    repeat (30) step();
    rst = 1; model_reset(); #1;
    check("rst_txv", txv, 0);
    check("rst_txd", txd, 0);
    check("rst_locked", lk, 0);
    check("rst_errc", errc, 0);
    repeat (3) step();
    rst = 0; mode = 2;
    repeat (40) step();
    check("post_rst_lock", lk, 2'b11);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
